// File: rtl/dcm_phase_sequencer_if.sv
// DCM dynamic phase-shift port bundle: PSEN/PSINCDEC towards the DCM,
// PSDONE/LOCKED back from it.
interface dcm_phase_sequencer_if;
   logic dcm_locked_i;
   logic dcm_psdone_i;
   logic dcm_psen_o;
   logic dcm_psincdec_o;

   modport master (
      input  dcm_locked_i,
      input  dcm_psdone_i,
      output dcm_psen_o,
      output dcm_psincdec_o
   );

   modport slave (
      output dcm_locked_i,
      output dcm_psdone_i,
      input  dcm_psen_o,
      input  dcm_psincdec_o
   );
endinterface

// File: rtl/dcm_phase_sequencer.sv
// Walks the DCM dynamic phase shift one step at a time from the applied
// offset to a saturated host target, with lock and PSDONE-timeout supervision.
module dcm_phase_sequencer #(
   parameter int PHASE_WIDTH    = 9,
   parameter int MAX_PHASE      = 255,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                          ftdi_clk,
   input  logic                          reset,
   input  logic signed [PHASE_WIDTH-1:0] phase_target_i,
   input  logic                          phase_load_i,
   dcm_phase_sequencer_if.master         dcm,
   output logic signed [PHASE_WIDTH-1:0] phase_current_o,
   output logic                          busy_o,
   output logic                          phase_done_o,
   output logic                          error_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic signed [PHASE_WIDTH-1:0] PMAX = PHASE_WIDTH'(MAX_PHASE);
   localparam logic signed [PHASE_WIDTH-1:0] PMIN = -PMAX;
   localparam logic signed [PHASE_WIDTH-1:0] ONE  = PHASE_WIDTH'(1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CHECK, STEP, WAIT} state_t;

   state_t                        state_r;
   logic signed [PHASE_WIDTH-1:0] target_r;
   logic signed [PHASE_WIDTH-1:0] current_r;
   logic [TW-1:0]                 timer_r;
   logic                          psen_r;
   logic                          psincdec_r;
   logic                          busy_r;
   logic                          done_r;
   logic                          error_r;

   function automatic logic signed [PHASE_WIDTH-1:0] sat_phase(
      input logic signed [PHASE_WIDTH-1:0] t
   );
      if (t > PMAX) begin
         sat_phase = PMAX;
      end else if (t < PMIN) begin
         sat_phase = PMIN;
      end else begin
         sat_phase = t;
      end
   endfunction

   // Sequencer FSM with all outputs registered on state transitions
   always_ff @(posedge ftdi_clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         target_r   <= '0;
         current_r  <= '0;
         timer_r    <= '0;
         psen_r     <= 1'b0;
         psincdec_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         psen_r <= 1'b0;
         if (phase_load_i) begin
            target_r <= sat_phase(phase_target_i);
            done_r   <= 1'b0;
            error_r  <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
               if (!dcm.dcm_locked_i) begin
                  current_r <= '0;
               end
               if (phase_load_i) begin
                  busy_r  <= 1'b1;
                  state_r <= CHECK;
               end
            end
            CHECK: begin
               // A load arriving here re-evaluates against the new target next cycle
               if (phase_load_i) begin
                  state_r <= CHECK;
               end else if (!dcm.dcm_locked_i) begin
                  error_r   <= 1'b1;
                  done_r    <= 1'b1;
                  current_r <= '0;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end else if (current_r == target_r) begin
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  psen_r     <= 1'b1;
                  psincdec_r <= (target_r > current_r);
                  state_r    <= STEP;
               end
            end
            STEP: begin
               timer_r <= '0;
               state_r <= WAIT;
            end
            WAIT: begin
               timer_r <= timer_r + TW'(1);
               if (dcm.dcm_psdone_i) begin
                  current_r <= psincdec_r ? (current_r + ONE) : (current_r - ONE);
                  state_r   <= CHECK;
               end else if (!dcm.dcm_locked_i) begin
                  current_r <= '0;
                  if (phase_load_i) begin
                     state_r <= CHECK;
                  end else begin
                     error_r <= 1'b1;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end else if (timer_r == TIMER_LAST) begin
                  if (phase_load_i) begin
                     state_r <= CHECK;
                  end else begin
                     error_r <= 1'b1;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end
               end else begin
                  state_r <= WAIT;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign dcm.dcm_psen_o     = psen_r;
   assign dcm.dcm_psincdec_o = psincdec_r;
   assign phase_current_o    = current_r;
   assign busy_o             = busy_r;
   assign phase_done_o       = done_r;
   assign error_o            = error_r;

endmodule

// File: tb/tb_dcm_phase_sequencer.sv
// Directed bench for dcm_phase_sequencer with a simple DCM model that
// answers each PSEN with a PSDONE pulse two cycles later.
module tb_dcm_phase_sequencer;
   logic              ftdi_clk;
   logic              reset;
   logic signed [8:0] phase_target_i;
   logic              phase_load_i;
   logic signed [8:0] phase_current_o;
   logic              busy_o;
   logic              phase_done_o;
   logic              error_o;

   dcm_phase_sequencer_if dcm_bus ();

   dcm_phase_sequencer #(
      .PHASE_WIDTH   (9),
      .MAX_PHASE     (255),
      .TIMEOUT_CYCLES(1023)
   ) dut (
      .ftdi_clk       (ftdi_clk),
      .reset          (reset),
      .phase_target_i (phase_target_i),
      .phase_load_i   (phase_load_i),
      .dcm            (dcm_bus),
      .phase_current_o(phase_current_o),
      .busy_o         (busy_o),
      .phase_done_o   (phase_done_o),
      .error_o        (error_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int inc_cnt  = 0;
   int dec_cnt  = 0;
   int i0, d0, cnt;
   logic       model_en;
   logic [1:0] pd_pipe;

   initial ftdi_clk = 1'b0;
   always #5 ftdi_clk = ~ftdi_clk;

   // DCM model: PSDONE pulse two cycles after each PSEN, plus step counters
   always @(posedge ftdi_clk) begin
      pd_pipe <= {pd_pipe[0], dcm_bus.dcm_psen_o & model_en};
      if (dcm_bus.dcm_psen_o) begin
         if (dcm_bus.dcm_psincdec_o) inc_cnt <= inc_cnt + 1;
         else                        dec_cnt <= dec_cnt + 1;
      end
   end
   assign dcm_bus.dcm_psdone_i = pd_pipe[1];

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic signed [8:0] t);
      @(negedge ftdi_clk);
      phase_target_i = t;
      phase_load_i   = 1'b1;
      @(negedge ftdi_clk);
      phase_load_i   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy_o && n < budget) begin
         @(negedge ftdi_clk);
         n++;
      end
      chk(tag, 32'(busy_o), 0);
   endtask

   task automatic wait_psen(input string tag);
      int n = 0;
      while (!dcm_bus.dcm_psen_o && n < 20) begin
         @(negedge ftdi_clk);
         n++;
      end
      chk(tag, 32'(dcm_bus.dcm_psen_o), 1);
   endtask

   initial begin
      reset          = 1'b1;
      phase_target_i = 9'sd0;
      phase_load_i   = 1'b0;
      model_en       = 1'b1;
      pd_pipe        = 2'b00;
      dcm_bus.dcm_locked_i = 1'b1;
      repeat (3) @(negedge ftdi_clk);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_psen", 32'(dcm_bus.dcm_psen_o), 0);
      chk("rst_current", 32'($signed(phase_current_o)), 0);
      reset = 1'b0;
      i0 = inc_cnt; d0 = dec_cnt;
      repeat (20) @(negedge ftdi_clk);
      chk("idle_psen_count", inc_cnt + dec_cnt - i0 - d0, 0);
      chk("idle_done", 32'(phase_done_o), 0);
      chk("idle_error", 32'(error_o), 0);
      chk("idle_incdec", 32'(dcm_bus.dcm_psincdec_o), 0);

      // +3 from zero
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(9'sd3);
      chk("p3_busy_after_load", 32'(busy_o), 1);
      wait_idle(200, "p3_finish");
      chk("p3_inc", inc_cnt - i0, 3);
      chk("p3_dec", dec_cnt - d0, 0);
      chk("p3_current", 32'($signed(phase_current_o)), 3);
      chk("p3_done", 32'(phase_done_o), 1);
      chk("p3_error", 32'(error_o), 0);

      // +3 to -2
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(-9'sd2);
      chk("m2_done_cleared", 32'(phase_done_o), 0);
      wait_idle(200, "m2_finish");
      chk("m2_dec", dec_cnt - d0, 5);
      chk("m2_inc", inc_cnt - i0, 0);
      chk("m2_current", 32'($signed(phase_current_o)), -2);
      chk("m2_done", 32'(phase_done_o), 1);

      // -256 saturates to -255
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(9'h100);
      wait_idle(3000, "sat_finish");
      chk("sat_current", 32'($signed(phase_current_o)), -255);
      chk("sat_dec", dec_cnt - d0, 253);
      chk("sat_done", 32'(phase_done_o), 1);

      // PSDONE withheld: timeout exactly 1023 cycles after WAIT entry
      model_en = 1'b0;
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(9'sd1);
      wait_psen("to_psen");
      @(negedge ftdi_clk);
      cnt = 0;
      while (!error_o && cnt < 2000) begin
         @(negedge ftdi_clk);
         cnt++;
      end
      chk("to_cycles", cnt, 1023);
      chk("to_error", 32'(error_o), 1);
      chk("to_done", 32'(phase_done_o), 1);
      chk("to_busy", 32'(busy_o), 0);
      chk("to_current", 32'($signed(phase_current_o)), -255);
      chk("to_inc", inc_cnt - i0, 1);

      // Lock loss during WAIT zeroes the offset
      do_load(9'sd5);
      chk("lk_error_cleared", 32'(error_o), 0);
      wait_psen("lk_psen");
      @(negedge ftdi_clk);
      dcm_bus.dcm_locked_i = 1'b0;
      @(negedge ftdi_clk);
      chk("lk_error", 32'(error_o), 1);
      chk("lk_done", 32'(phase_done_o), 1);
      chk("lk_current", 32'($signed(phase_current_o)), 0);
      chk("lk_busy", 32'(busy_o), 0);
      dcm_bus.dcm_locked_i = 1'b1;
      model_en = 1'b1;
      repeat (4) @(negedge ftdi_clk);

      // Retarget mid-flight: +10, then 2 once the 4->5 step is issued
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(9'sd10);
      cnt = 0;
      while (phase_current_o != 9'sd4 && cnt < 200) begin
         @(negedge ftdi_clk);
         cnt++;
      end
      chk("rt_reach4", 32'($signed(phase_current_o)), 4);
      wait_psen("rt_psen");
      do_load(9'sd2);
      chk("rt_busy", 32'(busy_o), 1);
      wait_idle(200, "rt_finish");
      chk("rt_current", 32'($signed(phase_current_o)), 2);
      chk("rt_inc", inc_cnt - i0, 5);
      chk("rt_dec", dec_cnt - d0, 3);
      chk("rt_done", 32'(phase_done_o), 1);

      // Target equal to current: two edges, no PSEN
      i0 = inc_cnt; d0 = dec_cnt;
      do_load(9'sd2);
      chk("eq_busy_k", 32'(busy_o), 1);
      chk("eq_done_k", 32'(phase_done_o), 0);
      @(negedge ftdi_clk);
      chk("eq_busy_k1", 32'(busy_o), 0);
      chk("eq_done_k1", 32'(phase_done_o), 1);
      chk("eq_psen_count", inc_cnt + dec_cnt - i0 - d0, 0);

      // Reset mid-sequence clears everything at once
      do_load(9'sd7);
      wait_psen("mr_psen");
      #1 reset = 1'b1;
      #1;
      chk("mr_psen", 32'(dcm_bus.dcm_psen_o), 0);
      chk("mr_busy", 32'(busy_o), 0);
      chk("mr_current", 32'($signed(phase_current_o)), 0);
      chk("mr_done", 32'(phase_done_o), 0);
      chk("mr_incdec", 32'(dcm_bus.dcm_psincdec_o), 0);
      repeat (2) @(negedge ftdi_clk);
      reset = 1'b0;
      repeat (2) @(negedge ftdi_clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/dcm_phase_sequencer.md
# dcm_phase_sequencer

Steps the capture-clock DCM's dynamic phase shift from its current offset to a host-requested target, one DCM step at a time. Sits between the host register interface (phase target, load strobe, status readback) and the DCM PSEN/PSINCDEC/PSDONE port.
- Tracks the absolute phase offset applied so far.
- Enforces a magnitude limit.
- Reports done, busy and error status back to the register file.

## Interface
- PHASE_WIDTH, 9, width of the signed phase target/current values
- MAX_PHASE, 255, magnitude limit; targets saturate to ±MAX_PHASE
- TIMEOUT_CYCLES, 1023, ftdi_clk cycles to wait for PSDONE before declaring error
- ftdi_clk  in  1  system clock; also drives the DCM PSCLK
- reset  in  1  asynchronous, active-high
- phase_target_i  in  PHASE_WIDTH  requested phase, two's complement
- phase_load_i  in  1  single-cycle strobe; latch target and start or retarget
- dcm_locked_i  in  1  DCM LOCKED
- dcm_psdone_i  in  1  DCM PSDONE, single-cycle pulse
- dcm_psen_o  out  1  DCM PSEN, single-cycle pulse per step
- dcm_psincdec_o  out  1  DCM PSINCDEC; 1 = increment
- phase_current_o  out  PHASE_WIDTH  signed offset applied so far
- busy_o  out  1  sequence in progress
- phase_done_o  out  1  sticky; set on completion or abort, cleared by load
- error_o  out  1  sticky; timeout or lock loss, cleared by load

## Operation
- Reset values:
  - FSM=IDLE.
  - dcm_psen_o, dcm_psincdec_o, busy_o, phase_done_o and error_o = 0.
  - phase_current_o = 0, target = 0, timer = 0.
- Target latch on phase_load_i:
  - Saturate to [-MAX_PHASE, +MAX_PHASE]. With defaults, -256 becomes -255.
  - Clear phase_done_o and error_o.
  - Accepted in any state.
- States:
  - IDLE:
    - busy_o=0.
    - phase_load_i → CHECK.
    - If dcm_locked_i=0, force phase_current_o to 0; a DCM reset returns the shift to zero.
  - CHECK:
    - busy_o=1.
    - If dcm_locked_i=0: error_o=1, phase_done_o=1, phase_current_o=0, → IDLE.
    - Else if current==target: phase_done_o=1, → IDLE.
    - Else → STEP.
  - STEP:
    - dcm_psen_o=1 for exactly this cycle.
    - dcm_psincdec_o = (target > current), signed compare; held until the next STEP.
    - Clear timer, → WAIT.
  - WAIT:
    - dcm_psen_o=0; the timer increments every cycle.
    - dcm_psdone_i=1: current ±1 per dcm_psincdec_o, → CHECK.
    - Else if dcm_locked_i=0: error_o=1, phase_done_o=1, current=0, → IDLE.
    - Else if timer==TIMEOUT_CYCLES-1: error_o=1, phase_done_o=1, current unchanged, → IDLE.
- Retarget while busy:
  - The new target overwrites the old one and phase_done_o clears.
  - An in-flight step (WAIT) completes normally.
  - The next CHECK uses the new target, so direction may reverse.
- Simultaneous dcm_psdone_i and timeout in the same cycle: psdone wins; no error.
- Simultaneous phase_load_i with the CHECK→IDLE completion: the load wins. Next state is CHECK, phase_done_o stays 0.
- dcm_psdone_i outside WAIT is ignored.
- phase_current_o never exceeds ±MAX_PHASE, so no wrap-around occurs.

## Timing
- All outputs are registered, and every state occupies at least one cycle.
- Per step, with phase_load_i sampled at edge k:
  - Edge k → CHECK.
  - k+1 → STEP: dcm_psen_o high in cycle k+1..k+2.
  - k+2 → WAIT.
- PSDONE sampled at edge j:
  - phase_current_o updated after j, state CHECK.
  - Next PSEN asserts after edge j+1.
- Minimum cost is 3 cycles per step plus DCM PSDONE latency.
- Completion: at the CHECK edge where current==target, busy_o falls and phase_done_o rises on the same edge.
- A load with target == current completes in 2 edges with no PSEN.
- Reset asserted mid-sequence: every output returns to its reset value immediately. The system resets the DCM alongside, keeping current=0 consistent.

## Test plan
- Reset, then idle 20 cycles → all outputs 0, no PSEN.
- DCM model with PSDONE 2 cycles after PSEN; load +3 → 3 PSEN pulses with psincdec=1; phase_current_o=3; done=1, busy=0, error=0.
- From +3, load -2 → 5 PSEN pulses with psincdec=0; current=-2; done=1.
- Load -256 → saturates; current reaches -255; done=1.
- Model withholds PSDONE; load +1 → single PSEN; error_o=1 and done=1 exactly TIMEOUT_CYCLES cycles after WAIT entry; current unchanged.
- Load +10; at current=4, load 2 → direction reverses after the in-flight step, ends at 2.
- Lock drops during WAIT → error=1, current=0.
